// File: rtl/enc_pkg.sv
// Shared types and quadrature step tables for the encoder emulator.
package enc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } enc_state_t;

   // {A, B} channel levels
   typedef logic [1:0] ab_t;

   localparam int unsigned DEFAULT_COUNTS_PER_REV = 300;

   // Next-state tables, 2 bits per entry, indexed by the current {A, B}.
   // Forward: 00->10->11->01->00; reverse: 00->01->11->10->00.
   localparam logic [7:0] FWD_NEXT = {2'b01, 2'b11, 2'b00, 2'b10};
   localparam logic [7:0] REV_NEXT = {2'b10, 2'b00, 2'b11, 2'b01};

   function automatic ab_t next_ab(input ab_t cur, input logic dir);
      logic [7:0] tbl;
      tbl = dir ? REV_NEXT : FWD_NEXT;
      return tbl[{cur, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/quad_encoder_emulator_step_timer.sv
// Step-period divider: one-cycle step_tick every max(period_in, 1) enabled cycles.
module step_timer #(
   parameter int unsigned DIV_WIDTH = 24
) (
   input  logic                 clk_in,
   input  logic                 rst_in_n,
   input  logic                 enable_in,
   input  logic [DIV_WIDTH-1:0] period_in,
   output logic                 step_tick
);

   logic [DIV_WIDTH-1:0] div_q;
   logic [DIV_WIDTH-1:0] last_cnt;

   // >= rather than == so a live drop of period_in below the running count
   // ticks at once instead of wrapping the whole divider range.
   always_comb begin
      last_cnt  = (period_in == '0) ? '0 : period_in - DIV_WIDTH'(1);
      step_tick = enable_in && (div_q >= last_cnt);
   end

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         div_q <= '0;
      end else if (!enable_in || step_tick) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + DIV_WIDTH'(1);
      end
   end

endmodule

// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: A/B/index generation for a commanded rate,
// direction and A-edge count, with abort and done handshake.
module quad_encoder_emulator
   import enc_pkg::*;
#(
   parameter int unsigned COUNTS_PER_REV = DEFAULT_COUNTS_PER_REV,
   parameter int unsigned DIV_WIDTH      = 24
) (
   input  logic                 clk_in,
   input  logic                 rst_in_n,
   input  logic                 start_in,
   input  logic                 stop_in,
   input  logic                 dir_in,
   input  logic [DIV_WIDTH-1:0] period_in,
   input  logic [15:0]          target_in,
   output logic                 enc_a_out,
   output logic                 enc_b_out,
   output logic                 index_out,
   output logic [15:0]          pos_out,
   output logic                 busy_out,
   output logic                 done_out
);

   localparam int unsigned      REV_W    = (COUNTS_PER_REV > 1) ? $clog2(COUNTS_PER_REV) : 1;
   localparam logic [REV_W-1:0] REV_LAST = REV_W'(COUNTS_PER_REV - 1);

   enc_state_t       state_q, state_d;
   ab_t              ab_q, ab_d;
   logic [15:0]      pos_q, pos_d;
   logic [15:0]      edge_cnt_q, edge_inc;
   logic [15:0]      target_q;
   logic [REV_W-1:0] rev_q, rev_d;
   logic             step_tick;
   logic             advance;
   logic             a_rise;
   logic             start_run;
   logic             finish;
   logic             index_d;

   step_timer #(
      .DIV_WIDTH(DIV_WIDTH)
   ) u_step_timer (
      .clk_in    (clk_in),
      .rst_in_n  (rst_in_n),
      .enable_in (state_q == RUN),
      .period_in (period_in),
      .step_tick (step_tick)
   );

   // Datapath: an abort on a tick edge wins, so no step is taken then.
   always_comb begin
      advance  = (state_q == RUN) && !stop_in && step_tick;
      ab_d     = advance ? next_ab(ab_q, dir_in) : ab_q;
      a_rise   = !ab_q[1] && ab_d[1];
      edge_inc = (edge_cnt_q == '1) ? edge_cnt_q : edge_cnt_q + 16'd1;

      pos_d = pos_q;
      if (advance) begin
         pos_d = dir_in ? pos_q - 16'd1 : pos_q + 16'd1;
      end

      rev_d = rev_q;
      if (a_rise) begin
         if (dir_in) begin
            rev_d = (rev_q == '0) ? REV_LAST : rev_q - REV_W'(1);
         end else begin
            rev_d = (rev_q == REV_LAST) ? '0 : rev_q + REV_W'(1);
         end
      end

      index_d = (rev_d == '0) && (ab_d == 2'b11);
      finish  = a_rise && (target_q != '0) && (edge_inc == target_q);
   end

   always_comb begin
      state_d   = state_q;
      start_run = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_in && !stop_in) begin
               state_d   = RUN;
               start_run = 1'b1;
            end
         end
         RUN: begin
            if (stop_in) begin
               state_d = IDLE;
            end else if (finish) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state_q    <= IDLE;
         ab_q       <= '0;
         pos_q      <= '0;
         rev_q      <= '0;
         edge_cnt_q <= '0;
         target_q   <= '0;
         index_out  <= 1'b0;
         busy_out   <= 1'b0;
         done_out   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ab_q      <= ab_d;
         pos_q     <= pos_d;
         rev_q     <= rev_d;
         index_out <= index_d;
         busy_out  <= (state_d == RUN);
         done_out  <= (state_d == DONE);
         if (start_run) begin
            target_q   <= target_in;
            edge_cnt_q <= '0;
         end else if (a_rise) begin
            edge_cnt_q <= edge_inc;
         end
      end
   end

   assign enc_a_out = ab_q[1];
   assign enc_b_out = ab_q[0];
   assign pos_out   = pos_q;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Self-checking bench: directed scenarios plus random stimulus against a
// position-based behavioural model (AB derived from position modulo 4).
module tb_quad_encoder_emulator;

   localparam int CPR = 300;
   localparam int DW  = 24;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, stop, dir;
   logic [DW-1:0] period;
   logic [15:0]   target;
   logic          enc_a, enc_b, index, busy, done;
   logic [15:0]   pos;

   quad_encoder_emulator #(
      .COUNTS_PER_REV(CPR),
      .DIV_WIDTH     (DW)
   ) dut (
      .clk_in   (clk),
      .rst_in_n (rst_n),
      .start_in (start),
      .stop_in  (stop),
      .dir_in   (dir),
      .period_in(period),
      .target_in(target),
      .enc_a_out(enc_a),
      .enc_b_out(enc_b),
      .index_out(index),
      .pos_out  (pos),
      .busy_out (busy),
      .done_out (done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_run, m_done;
   int m_pos, m_rev, m_edges, m_target, m_cnt;

   function automatic logic [1:0] gray(input int p);
      case (p & 3)
         0:       return 2'b00;
         1:       return 2'b10;
         2:       return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

   task automatic model_reset();
      m_run = 0; m_done = 0; m_pos = 0; m_rev = 0;
      m_edges = 0; m_target = 0; m_cnt = 0;
   endtask

   task automatic model_step();
      int p;
      logic [1:0] o, n;
      p = (period == '0) ? 1 : int'(period);
      if (m_done) begin
         m_done = 0;
      end else if (!m_run) begin
         if (start && !stop) begin
            m_run = 1; m_target = int'(target); m_edges = 0; m_cnt = 0;
         end
      end else if (stop) begin
         m_run = 0;
      end else begin
         m_cnt++;
         if (m_cnt >= p) begin
            m_cnt = 0;
            o = gray(m_pos);
            m_pos = dir ? m_pos - 1 : m_pos + 1;
            n = gray(m_pos);
            if (!o[1] && n[1]) begin
               if (m_edges < 65535) m_edges++;
               m_rev = (m_rev + (dir ? CPR - 1 : 1)) % CPR;
               if (m_target != 0 && m_edges == m_target) begin
                  m_run = 0; m_done = 1;
               end
            end
         end
      end
   endtask

   // ---------------- monitor / compare ----------------
   int         cyc = 0;
   logic [1:0] prev_ab = 2'b00;
   logic       prev_busy = 1'b0, prev_idx = 1'b0;
   int         a_rise_q[$];
   int         b_rise_q[$];
   int         busy_rise_cyc, done_cyc, done_pulses, idx_pulses, idx_high;

   task automatic clear_mon();
      a_rise_q.delete(); b_rise_q.delete();
      busy_rise_cyc = -1; done_cyc = -1;
      done_pulses = 0; idx_pulses = 0; idx_high = 0;
   endtask

   always @(negedge rst_n) begin
      model_reset();
      prev_ab = 2'b00;
   end

   always @(posedge clk) begin
      logic [1:0] e_ab;
      cyc++;
      if (!rst_n) model_reset();
      else        model_step();
      #1;
      e_ab = gray(m_pos);
      check("enc_a", {31'd0, enc_a}, {31'd0, e_ab[1]});
      check("enc_b", {31'd0, enc_b}, {31'd0, e_ab[0]});
      check("index", {31'd0, index}, {31'd0, (m_rev == 0 && e_ab == 2'b11)});
      check("pos",   {16'd0, pos},   {16'd0, 16'(m_pos)});
      check("busy",  {31'd0, busy},  {31'd0, m_run});
      check("done",  {31'd0, done},  {31'd0, m_done});
      check("one_channel", {31'd0, ($countones({enc_a, enc_b} ^ prev_ab) <= 1)}, 32'd1);
      if (enc_a && !prev_ab[1]) a_rise_q.push_back(cyc);
      if (enc_b && !prev_ab[0]) b_rise_q.push_back(cyc);
      if (busy && !prev_busy) busy_rise_cyc = cyc;
      if (done) begin done_pulses++; done_cyc = cyc; end
      if (index && !prev_idx) idx_pulses++;
      if (index) idx_high++;
      prev_ab   = {enc_a, enc_b};
      prev_busy = busy;
      prev_idx  = index;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(1); start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; tick(1); stop = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0;
      tick(2); rst_n = 1'b1;
      tick(1);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int k = 0;
      while (busy && k < budget) begin tick(1); k++; end
      check(tag, {31'd0, busy}, 32'd0);
      tick(2);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0;
      period = '0; target = '0;
      clear_mon();
      tick(3);
      check("rst_ab",   {30'd0, enc_a, enc_b}, 32'd0);
      check("rst_pos",  {16'd0, pos}, 32'd0);
      check("rst_busy", {29'd0, busy, done, index}, 32'd0);
      rst_n = 1'b1;
      tick(2);

      // Forward, period 4, three A rises
      period = 24'd4; target = 16'd3; dir = 1'b0;
      clear_mon();
      pulse_start();
      wait_idle(300, "t1_timeout");
      check("t1_a_rises",  a_rise_q.size(), 32'd3);
      if (a_rise_q.size() >= 3 && b_rise_q.size() >= 1) begin
         check("t1_first_lat", a_rise_q[0] - busy_rise_cyc, 32'd4);
         check("t1_a_period",  a_rise_q[1] - a_rise_q[0], 32'd16);
         check("t1_b_lag",     b_rise_q[0] - a_rise_q[0], 32'd4);
         check("t1_done_at",   done_cyc, a_rise_q[2]);
      end
      check("t1_done_cnt", done_pulses, 32'd1);
      check("t1_pos",      {16'd0, pos}, 32'd9);

      // Reverse, period 1, two A rises
      do_reset();
      period = 24'd1; target = 16'd2; dir = 1'b1;
      clear_mon();
      pulse_start();
      wait_idle(100, "t2_timeout");
      check("t2_a_rises", a_rise_q.size(), 32'd2);
      if (a_rise_q.size() >= 1 && b_rise_q.size() >= 1)
         check("t2_b_leads", a_rise_q[0] - b_rise_q[0], 32'd1);
      check("t2_done_cnt", done_pulses, 32'd1);
      check("t2_pos", {16'd0, pos}, 32'h0000_FFFA);

      // Three revolutions: prime rev_pos to 1, then 900 edges
      do_reset();
      period = 24'd1; target = 16'd1; dir = 1'b0;
      pulse_start();
      wait_idle(50, "t3a_timeout");
      target = 16'd900;
      clear_mon();
      pulse_start();
      wait_idle(5000, "t3_timeout");
      check("t3_a_rises",  a_rise_q.size(), 32'd900);
      check("t3_idx",      idx_pulses, 32'd3);
      check("t3_idx_wide", idx_high, 32'd3);
      check("t3_done_cnt", done_pulses, 32'd1);
      check("t3_pos",      {16'd0, pos}, 32'd3601);

      // Free run with period 0, then abort and restart
      period = '0; target = '0; dir = 1'b0;
      clear_mon();
      pulse_start();
      tick(1000);
      pulse_stop();
      check("t4_busy_fall", {31'd0, busy}, 32'd0);
      tick(5);
      check("t4_no_done", done_pulses, 32'd0);
      check("t4_edges",   {31'd0, (a_rise_q.size() > 200)}, 32'd1);
      period = 24'd3;
      pulse_start();
      tick(20);
      pulse_stop();
      tick(3);

      // Direction flip right after AB = 11
      period = 24'd2; target = '0; dir = 1'b0;
      pulse_start();
      begin
         int k = 0;
         while (!(enc_a && enc_b) && k < 40) begin tick(1); k++; end
         check("t5_reach_11", {30'd0, enc_a, enc_b}, 32'd3);
         dir = 1'b1;
         k = 0;
         while (enc_a && enc_b && k < 40) begin tick(1); k++; end
         check("t5_after_flip", {30'd0, enc_a, enc_b}, 32'd2);
      end
      tick(10);
      pulse_stop();
      tick(2);

      // Asynchronous reset mid-run
      period = 24'd2; dir = 1'b0;
      pulse_start();
      tick(9);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("t6_async_ab",  {30'd0, enc_a, enc_b}, 32'd0);
      check("t6_async_pos", {16'd0, pos}, 32'd0);
      check("t6_async_ctl", {29'd0, busy, done, index}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      tick(2);

      // Simultaneous start/stop in IDLE stays idle
      start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
      tick(2);
      check("t7_stay_idle", {31'd0, busy}, 32'd0);

      // Random traffic
      for (int i = 0; i < 2500; i++) begin
         start  = ($urandom_range(0, 7) == 0);
         stop   = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 29) == 0) dir = ~dir;
         if ($urandom_range(0, 9) == 0) period = DW'($urandom_range(0, 3));
         target = 16'($urandom_range(0, 6));
         tick(1);
      end
      start = 1'b0; stop = 1'b0;
      tick(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
